// File: rtl/ha_serial_accum.sv
// ha_serial_accum: bit-serial adder stage.
// Takes operand bit pairs (a, b) LSB-first, one pair per in_valid/in_ready
// handshake. It keeps a running carry and collects the sum bits in a shift
// register. After W bits it presents the W-bit sum and the carry-out on a
// valid/ready output, and holds them there until the consumer takes them.
// Optional feature macro: HA_SERIAL_SAT_EN. When it is defined, a final carry
// saturates the result to all ones and raises ovf. When it is undefined, the
// result is the modulo-2^W sum and ovf is tied to 0.
module ha_serial_accum #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena,
  input  logic         clr,
  input  logic         in_valid,
  input  logic         in_a,
  input  logic         in_b,
  output logic         in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         cout,
  output logic         busy,
  output logic         ovf
);

  localparam int CNT_W = $clog2(W + 1);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t             state_q,     state_d;
  logic [CNT_W-1:0]   bit_cnt_q,   bit_cnt_d;
  logic               carry_q,     carry_d;
  logic [W-1:0]       shift_q,     shift_d;
  logic [W-1:0]       result_q,    result_d;
  logic               cout_q,      cout_d;
  logic               out_valid_q, out_valid_d;
`ifdef HA_SERIAL_SAT_EN
  logic               ovf_q,       ovf_d;
`endif

  logic               accept;
  logic               take;
  logic               last_bit;
  logic               sum_bit;
  logic               carry_nxt;
  logic [W-1:0]       shift_nxt;

  // Full-adder slice that folds the incoming bit pair into the running carry.
  assign sum_bit   = in_a ^ in_b ^ carry_q;
  assign carry_nxt = (in_a & in_b) | (carry_q & (in_a ^ in_b));
  assign shift_nxt = {sum_bit, shift_q[W-1:1]};

  assign in_ready  = (state_q == ACCUM) & ena;
  assign accept    = in_valid & in_ready;
  assign take      = out_valid_q & out_ready & ena;
  assign last_bit  = (bit_cnt_q == CNT_W'(W - 1));

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign cout      = cout_q;
  assign busy      = (bit_cnt_q != '0);
`ifdef HA_SERIAL_SAT_EN
  assign ovf       = ovf_q;
`else
  assign ovf       = 1'b0;
`endif

  // Next-state logic. clr outranks the handshakes, and ena=0 freezes everything.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    carry_d     = carry_q;
    shift_d     = shift_q;
    result_d    = result_q;
    cout_d      = cout_q;
    out_valid_d = out_valid_q;
`ifdef HA_SERIAL_SAT_EN
    ovf_d       = ovf_q;
`endif
    if (ena) begin
      if (clr) begin
        // Abort. The last presented result/cout stay visible.
        state_d     = ACCUM;
        bit_cnt_d   = '0;
        carry_d     = 1'b0;
        shift_d     = '0;
        out_valid_d = 1'b0;
`ifdef HA_SERIAL_SAT_EN
        ovf_d       = 1'b0;
`endif
      end else begin
        unique case (state_q)
          ACCUM: begin
            if (accept) begin
              shift_d = shift_nxt;
              if (last_bit) begin
                // The final bit goes straight into the output registers.
`ifdef HA_SERIAL_SAT_EN
                result_d = carry_nxt ? {W{1'b1}} : shift_nxt;
                ovf_d    = carry_nxt;
`else
                result_d = shift_nxt;
`endif
                cout_d      = carry_nxt;
                out_valid_d = 1'b1;
                carry_d     = 1'b0;
                bit_cnt_d   = '0;
                state_d     = HOLD;
              end else begin
                carry_d   = carry_nxt;
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
              end
            end
          end
          HOLD: begin
            // No bypass: accepting restarts on the cycle after the take.
            if (take) begin
              out_valid_d = 1'b0;
              state_d     = ACCUM;
            end
          end
          default: state_d = ACCUM;
        endcase
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      bit_cnt_q   <= '0;
      carry_q     <= 1'b0;
      shift_q     <= '0;
      result_q    <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef HA_SERIAL_SAT_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      carry_q     <= carry_d;
      shift_q     <= shift_d;
      result_q    <= result_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
`ifdef HA_SERIAL_SAT_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

endmodule

// File: tb/tb_ha_serial_accum.sv
// Self-checking bench for ha_serial_accum (W=8).
// It uses a vector table, hand-written corner sequences, and randomized
// operands. Each result is checked against a plain-arithmetic model.
module tb_ha_serial_accum;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ena;
  logic         clr;
  logic         in_valid;
  logic         in_a;
  logic         in_b;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         cout;
  logic         busy;
  logic         ovf;

  int n_cmp = 0;
  int n_bad = 0;
  bit rand_gaps = 1'b0;

  ha_serial_accum #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .busy      (busy),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_r;
    logic         exp_c;
    logic         exp_ovf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: the sum of two W-bit numbers, plus optional saturation.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] r, output logic c, output logic o);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    c = s[W];
`ifdef HA_SERIAL_SAT_EN
    r = c ? {W{1'b1}} : s[W-1:0];
    o = c;
`else
    r = s[W-1:0];
    o = 1'b0;
`endif
  endtask

  // Feed bits lo..hi of a/b, waiting (bounded) for in_ready on each one.
  task automatic send_range(input logic [W-1:0] a, input logic [W-1:0] b,
                            input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      if (rand_gaps && $urandom_range(0, 3) == 0) begin
        ena = 1'b0;
        step();
        ena = 1'b1;
      end
      in_a = a[i];
      in_b = b[i];
      in_valid = 1'b1;
      #1;
      for (int g = 0; !in_ready; g++) begin
        if (g > 50) begin
          chk("in_ready_timeout", 32'(in_ready), 32'd1);
          break;
        end
        step();
      end
      step();
    end
    in_valid = 1'b0;
  endtask

  // Feed a full operand. out_valid must be up right after the edge that took bit W-1.
  task automatic send_operand(input logic [W-1:0] a, input logic [W-1:0] b);
    send_range(a, b, 0, W - 1);
    chk("out_valid_latency", 32'(out_valid), 32'd1);
  endtask

  // Wait (bounded) for a result, check it, take it, and confirm it is released.
  task automatic get_result(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                            input int delay);
    logic [W-1:0] er;
    logic ec, eo;
    model(a, b, er, ec, eo);
    for (int g = 0; !out_valid; g++) begin
      if (g > 50) begin
        chk("out_valid_timeout", 32'(out_valid), 32'd1);
        break;
      end
      step();
    end
    for (int d = 0; d < delay; d++) step();
    $display("xfer %s: a=%02h b=%02h -> result=%02h cout=%0d ovf=%0d (exp %02h/%0d/%0d)",
             name, a, b, result, cout, ovf, er, ec, eo);
    chk({name, "_result"}, 32'(result), 32'(er));
    chk({name, "_cout"},   32'(cout),   32'(ec));
    chk({name, "_ovf"},    32'(ovf),    32'(eo));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({name, "_released"}, 32'(out_valid), 32'd0);
  endtask

  vec_t vecs[6];

  initial begin
    logic [W-1:0] ra, rb, held;
    logic [W-1:0] er;
    logic ec, eo;

    vecs[0] = '{a: 8'h5A, b: 8'h33, exp_r: 8'h8D, exp_c: 1'b0, exp_ovf: 1'b0};
    vecs[1] = '{a: 8'h00, b: 8'h00, exp_r: 8'h00, exp_c: 1'b0, exp_ovf: 1'b0};
    vecs[2] = '{a: 8'h7F, b: 8'h01, exp_r: 8'h80, exp_c: 1'b0, exp_ovf: 1'b0};
`ifdef HA_SERIAL_SAT_EN
    vecs[3] = '{a: 8'hFF, b: 8'h01, exp_r: 8'hFF, exp_c: 1'b1, exp_ovf: 1'b1};
    vecs[4] = '{a: 8'hFF, b: 8'hFF, exp_r: 8'hFF, exp_c: 1'b1, exp_ovf: 1'b1};
    vecs[5] = '{a: 8'h80, b: 8'h80, exp_r: 8'hFF, exp_c: 1'b1, exp_ovf: 1'b1};
`else
    vecs[3] = '{a: 8'hFF, b: 8'h01, exp_r: 8'h00, exp_c: 1'b1, exp_ovf: 1'b0};
    vecs[4] = '{a: 8'hFF, b: 8'hFF, exp_r: 8'hFE, exp_c: 1'b1, exp_ovf: 1'b0};
    vecs[5] = '{a: 8'h80, b: 8'h80, exp_r: 8'h00, exp_c: 1'b1, exp_ovf: 1'b0};
`endif

    rst_n = 1'b0; ena = 1'b1; clr = 1'b0; in_valid = 1'b0;
    in_a = 1'b0; in_b = 1'b0; out_ready = 1'b0;
    repeat (2) step();
    chk("rst_result",    32'(result),    32'd0);
    chk("rst_cout",      32'(cout),      32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_ovf",       32'(ovf),       32'd0);
    rst_n = 1'b1;
    step();
    chk("rst_in_ready",  32'(in_ready),  32'd1);

    // Table vectors, with out_ready held high so out_valid is a one-cycle pulse.
    foreach (vecs[i]) begin
      out_ready = 1'b1;
      send_operand(vecs[i].a, vecs[i].b);
      $display("xfer vec%0d: a=%02h b=%02h -> result=%02h cout=%0d ovf=%0d",
               i, vecs[i].a, vecs[i].b, result, cout, ovf);
      chk($sformatf("vec%0d_result", i), 32'(result), 32'(vecs[i].exp_r));
      chk($sformatf("vec%0d_cout", i),   32'(cout),   32'(vecs[i].exp_c));
      chk($sformatf("vec%0d_ovf", i),    32'(ovf),    32'(vecs[i].exp_ovf));
      step();
      chk($sformatf("vec%0d_pulse", i),  32'(out_valid), 32'd0);
      out_ready = 1'b0;
    end

    // Backpressure: the result is held for 5 cycles while in_valid stays high.
    send_operand(8'h12, 8'h34);
    held = result;
    chk("bp_result", 32'(held), 32'h46);
    in_valid = 1'b1; in_a = 1'b1; in_b = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("bp_in_ready", 32'(in_ready),  32'd0);
      chk("bp_stable",   32'(result),    32'(held));
      chk("bp_valid",    32'(out_valid), 32'd1);
      chk("bp_busy",     32'(busy),      32'd0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_take_valid",  32'(out_valid), 32'd0);
    chk("bp_take_nobit",  32'(busy),      32'd0);
    chk("bp_ready_after", 32'(in_ready),  32'd1);
    step();
    chk("bp_first_accept", 32'(busy), 32'd1);
    in_valid = 1'b0;
    send_range(8'hFF, 8'h01, 1, W - 1);
    get_result("bp_next", 8'hFF, 8'h01, 0);

    // Clear after 3 bits that leave a live carry.
    held = result;
    send_range(8'hFF, 8'hFF, 0, 2);
    chk("clr_busy_before", 32'(busy), 32'd1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_busy",   32'(busy),      32'd0);
    chk("clr_valid",  32'(out_valid), 32'd0);
    chk("clr_result", 32'(result),    32'(held));
    send_operand(8'h01, 8'h01);
    get_result("clr_next", 8'h01, 8'h01, 0);

    // Asynchronous reset in the middle of an operand.
    send_range(8'hAA, 8'h55, 0, 3);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_result", 32'(result),    32'd0);
    chk("arst_cout",   32'(cout),      32'd0);
    chk("arst_valid",  32'(out_valid), 32'd0);
    chk("arst_busy",   32'(busy),      32'd0);
    step();
    rst_n = 1'b1;
    step();
    send_operand(8'h3C, 8'h0F);
    get_result("arst_next", 8'h3C, 8'h0F, 0);

    // ena low for 4 cycles mid-operand with in_valid high.
    send_range(8'hC9, 8'h5B, 0, 2);
    ena = 1'b0; in_valid = 1'b1; in_a = 1'b1; in_b = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("ena_in_ready", 32'(in_ready), 32'd0);
      step();
      chk("ena_busy", 32'(busy), 32'd1);
    end
    ena = 1'b1;
    send_range(8'hC9, 8'h5B, 3, W - 1);
    get_result("ena_resume", 8'hC9, 8'h5B, 1);

    // Randomized operands with ena gaps and random output backpressure.
    rand_gaps = 1'b1;
    for (int n = 0; n < 40; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      model(ra, rb, er, ec, eo);
      send_operand(ra, rb);
      get_result($sformatf("rand%0d", n), ra, rb, $urandom_range(0, 3));
    end
    rand_gaps = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
